// File: rtl/prog_loader.sv
// Boot loader: streams 32-bit instruction words into Mem4K port A from BASE_ADDR upward, appends TERM_WORD, then hands port A to core fetch.
// Latency: each accepted word is written in its handshake cycle; TERM is written the next cycle; core_rst falls HOLD_CYCLES cycles after TERM.
// Backpressure: s_ready is high only in LOAD (one word per cycle); in every other state the source must hold its word.
// Build option: define PROG_LOADER_CHECKSUM_EN to treat the s_last word as a 32-bit wraparound checksum of the image.

`ifndef MM_ENB_W
`define MM_ENB_W 1'b1
`endif
`ifndef MM_ENB_R
`define MM_ENB_R 1'b0
`endif

module prog_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'd2048,
    parameter int          MAX_WORDS   = 511,
    parameter logic [31:0] TERM_WORD   = 32'hFFFF0000,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic        clk_base,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        core_rst,
    input  logic [31:0] I_ABus,
    output logic [31:0] I_DBus,
    output logic        A_EnWR,
    output logic [31:0] A_ABus,
    output logic [31:0] A_DBusW,
    input  logic [31:0] A_DBusR,
    output logic        done,
    output logic        error,
    output logic [9:0]  word_cnt
);

    localparam logic [9:0]  MAX_CNT   = 10'(MAX_WORDS);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TERM,
        ST_HOLD,
        ST_RUN,
        ST_ERROR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] wr_addr;
    logic [9:0]  cnt;
    logic [15:0] hold_cnt;
    logic        wr_adv;
    logic        hs;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] sum;
`endif

    assign hs       = s_valid & s_ready;
    assign core_rst = (state != ST_RUN);
    assign done     = (state == ST_RUN);
    assign error    = (state == ST_ERROR);
    assign I_DBus   = A_DBusR;
    assign word_cnt = cnt;

    // Next state, stream ready and port A steering; port A is read-only unless a word or TERM is being written.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        A_EnWR    = `MM_ENB_R;
        A_ABus    = wr_addr;
        A_DBusW   = s_data;
        wr_adv    = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_LOAD;
            ST_LOAD: begin
                s_ready = 1'b1;
                if (hs) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    // The checksum word occupies no slot, so it may arrive with the image full.
                    if (s_last) begin
                        state_nxt = (sum == s_data) ? ST_TERM : ST_ERROR;
                    end else if (cnt == MAX_CNT) begin
                        state_nxt = ST_ERROR;
                    end else begin
                        A_EnWR = `MM_ENB_W;
                        wr_adv = 1'b1;
                    end
`else
                    // With the image full only TERM_WORD still fits, so any further program word overflows.
                    if (cnt == MAX_CNT) begin
                        state_nxt = ST_ERROR;
                    end else begin
                        A_EnWR = `MM_ENB_W;
                        wr_adv = 1'b1;
                        if (s_last) begin
                            state_nxt = ST_TERM;
                        end
                    end
`endif
                end
            end
            ST_TERM: begin
                A_EnWR    = `MM_ENB_W;
                A_DBusW   = TERM_WORD;
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:   A_ABus = I_ABus;
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register, write pointer, word count and hold timer; rst restarts a fresh load.
    always_ff @(posedge clk_base) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_addr  <= BASE_ADDR;
            cnt      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= (state == ST_HOLD) ? hold_cnt + 16'd1 : 16'd0;
            if (wr_adv) begin
                wr_addr <= wr_addr + 32'd4;
                cnt     <= cnt + 10'd1;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running wraparound sum of accepted program words, compared against the s_last word.
    always_ff @(posedge clk_base) begin
        if (rst) begin
            sum <= '0;
        end else if (state == ST_LOAD && hs && !s_last) begin
            sum <= sum + s_data;
        end
    end
`endif

endmodule
